// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int NUM_REQ_DEF  = 8;
  localparam int MAX_HOLD_DEF = 16;

  // Wide one-hot; callers truncate to their own requester count.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/arb_lsb_encoder.sv
// Lowest-set-bit priority encoder: index of the lowest set bit of vec, plus any-set flag.
module arb_lsb_encoder #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan high to low so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant held until release (explicit, implicit or forced).
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
`ifdef ARB_TIMEOUT_EN
  parameter int MAX_HOLD = MAX_HOLD_DEF,
`endif
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               release_in,
  output logic [NUM_REQ-1:0] gnt_out,
  output logic [IDX_W-1:0]   gnt_idx_out,
`ifdef ARB_TIMEOUT_EN
  output logic               timeout_out,
`endif
  output logic               gnt_vld_out
);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   ptr, gnt_idx, m_idx, u_idx, win_idx;
  logic               gnt_vld, m_any, u_any;
  logic [NUM_REQ-1:0] mask_lo, masked, others;
  logic               busy, owner_req, timeout_hit, end_own, do_grant, do_drop;

  // Requesters below ptr are masked off so the search starts at ptr.
  assign mask_lo = (NUM_REQ'(1) << ptr) - NUM_REQ'(1);
  assign masked  = req_in & ~mask_lo;

  arb_lsb_encoder #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc_masked (
    .vec(masked), .idx(m_idx), .any(m_any)
  );
  arb_lsb_encoder #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc_unmasked (
    .vec(req_in), .idx(u_idx), .any(u_any)
  );

  assign win_idx = m_any ? m_idx : u_idx;

  assign busy      = (state == ARB_BUSY);
  assign owner_req = req_in[gnt_idx];
  assign others    = req_in & ~gnt_out;
  assign end_own   = busy & (release_in | ~owner_req | timeout_hit);

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_drop   = 1'b0;
    case (state)
      ARB_IDLE: if (u_any) begin
        do_grant  = 1'b1;
        state_nxt = ARB_BUSY;
      end
      ARB_BUSY: if (end_own) begin
        // Owner stays in req_in but ptr is past it, so it cannot win while others wait.
        if (|others) begin
          do_grant = 1'b1;
        end else begin
          do_drop   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        gnt_idx <= win_idx;
        gnt_vld <= 1'b1;
        ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end else if (do_drop) begin
        gnt_vld <= 1'b0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_cnt;

  assign timeout_hit = busy & (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      timeout_out <= 1'b0;
    end else begin
      // Pulse only when the counter, not the owner, ended the grant.
      timeout_out <= timeout_hit & ~release_in & owner_req;
      if (do_grant || do_drop) hold_cnt <= '0;
      else if (busy)           hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign gnt_vld_out = gnt_vld;
  assign gnt_idx_out = gnt_idx;
  assign gnt_out     = gnt_vld ? NUM_REQ'(onehot(32'(gnt_idx))) : '0;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (NUM_REQ=8, MAX_HOLD=4) with an expected-output queue.
module tb_rr_arbiter;

  localparam int N = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic         release_in = 1'b0;
  logic [N-1:0] gnt_out;
  logic [2:0]   gnt_idx_out;
  logic         gnt_vld_out;
`ifdef ARB_TIMEOUT_EN
  logic         timeout_out;
`endif

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rr_arbiter #(
    .NUM_REQ(N)
`ifdef ARB_TIMEOUT_EN
    , .MAX_HOLD(4)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_in(req_in),
    .release_in(release_in),
    .gnt_out(gnt_out),
    .gnt_idx_out(gnt_idx_out),
`ifdef ARB_TIMEOUT_EN
    .timeout_out(timeout_out),
`endif
    .gnt_vld_out(gnt_vld_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    logic [N-1:0] g;
    g = e.vld ? (N'(1) << e.idx) : '0;
    check({tag, ".vld"}, 32'(gnt_vld_out), 32'(e.vld));
    check({tag, ".gnt"}, 32'(gnt_out), 32'(g));
    check({tag, ".idx"}, 32'(gnt_idx_out), 32'(e.idx));
`ifdef ARB_TIMEOUT_EN
    check({tag, ".to"}, 32'(timeout_out), 32'(e.to));
`endif
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic cyc(input string tag, input logic [N-1:0] req, input logic rel,
                     input logic vld, input logic [2:0] idx, input logic to);
    exp_t e;
    req_in     = req;
    release_in = rel;
    sb.push_back('{vld: vld, idx: idx, to: to});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_in     = '0;
    release_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state and idle with no requests
    #2;
    compare_outputs("reset", '{vld: 1'b0, idx: 3'd0, to: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("idle", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // 2: single requester, hold, release, release while idle ignored
    cyc("t2.grant", 8'h01, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("t2.hold1", 8'h01, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("t2.hold2", 8'h01, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("t2.rel",   8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc("t2.idlerel", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // 3: all requesting, release each grant -> 0..7,0 with no bubble
    do_reset();
    cyc("t3.first", 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 1; k <= 8; k++) cyc("t3.rr", 8'hFF, 1'b1, 1'b1, 3'(k % 8), 1'b0);
    cyc("t3.drain", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // 4: pointer at 5 skips 0 for 6, then wraps to 0
    do_reset();
    cyc("t4.g4",   8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
    cyc("t4.g6",   8'h41, 1'b0, 1'b1, 3'd6, 1'b0);
    cyc("t4.g0",   8'h41, 1'b1, 1'b1, 3'd0, 1'b0);
    cyc("t4.idle", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // 5: implicit release, then reset mid-grant restarts search at ptr 0
    do_reset();
    cyc("t5.g2",   8'h04, 1'b0, 1'b1, 3'd2, 1'b0);
    cyc("t5.hold", 8'h84, 1'b0, 1'b1, 3'd2, 1'b0);
    cyc("t5.g7",   8'h80, 1'b0, 1'b1, 3'd7, 1'b0);
    cyc("t5.g1",   8'h22, 1'b1, 1'b1, 3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    compare_outputs("t5.midrst", '{vld: 1'b0, idx: 3'd0, to: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5.ptr0", 8'h22, 1'b0, 1'b1, 3'd1, 1'b0);

    // 6: held grant with no release
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) cyc("t6.hold", 8'h03, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("t6.force", 8'h03, 1'b0, 1'b1, 3'd1, 1'b1);
    cyc("t6.after", 8'h03, 1'b0, 1'b1, 3'd1, 1'b0);
`else
    for (int i = 0; i < 100; i++) cyc("t6.hold", 8'h03, 1'b0, 1'b1, 3'd0, 1'b0);
`endif

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
